// File: rtl/risc16_muldiv.sv
// risc16_muldiv: iterative multiply/divide unit for the RISC16 EX stage.
// One bit-step per clock over WIDTH cycles, start/busy/done handshake,
// flush kills an in-flight operation.
// Optional feature macro: MULDIV_SIGNED_EN (two's-complement operands when
// sgn=1). Without it sgn is ignored and no sign logic is built.
//
// Handshake: start is taken only in a cycle where busy=0 and flush=0
// (IDLE or FIN). busy is high for exactly WIDTH cycles after the accept
// cycle; done pulses for one cycle right after, with result/div_by_zero
// valid and held until the next completion. flush in RUN/FIN returns to
// IDLE without a done pulse and without touching result/div_by_zero.
module risc16_muldiv #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             flush,
  input  logic [1:0]       op,
  input  logic             sgn,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             div_by_zero,
  output logic [1:0]       dbg_state
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIN  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [1:0]       op_q, op_d;
  // opnd holds the multiplicand (MUL) or the divisor (DIV/REM)
  logic [WIDTH-1:0] opnd_q, opnd_d;
  // hi: upper accumulator half / partial remainder
  logic [WIDTH-1:0] hi_q, hi_d;
  // lo: multiplier being shifted out / dividend shifting into quotient
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             bz_q, bz_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             dbz_q, dbz_d;

  logic             accept;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] mul_hi, mul_lo;
  logic [WIDTH:0]   div_sh;
  logic [WIDTH-1:0] div_diff, div_hi, div_lo;
  logic             div_ok;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0] quot, remv, final_res;

`ifdef MULDIV_SIGNED_EN
  logic             qneg_q, qneg_d;
  logic             rneg_q, rneg_d;
  logic             sa, sb;

  // Operand signs and magnitudes captured at issue; 0x8000 stays 0x8000
  always_comb begin
    sa    = sgn & a[WIDTH-1];
    sb    = sgn & b[WIDTH-1];
    mag_a = sa ? (~a + 1'b1) : a;
    mag_b = sb ? (~b + 1'b1) : b;
  end
`else
  logic unused_sgn;
  assign unused_sgn = sgn;
  assign mag_a = a;
  assign mag_b = b;
`endif

  assign accept = start && !flush && (state_q != S_RUN);

  // One datapath step for both shift-add multiply and restoring divide
  always_comb begin
    mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
    mul_hi   = mul_sum[WIDTH:1];
    mul_lo   = {mul_sum[0], lo_q[WIDTH-1:1]};
    div_sh   = {hi_q, lo_q[WIDTH-1]};
    div_ok   = (div_sh >= {1'b0, opnd_q});
    div_diff = div_sh[WIDTH-1:0] - opnd_q;
    div_hi   = div_ok ? div_diff : div_sh[WIDTH-1:0];
    div_lo   = {lo_q[WIDTH-2:0], div_ok};
  end

  // Result selection with sign fix-up, applied on the last RUN step
  always_comb begin
    prod = {mul_hi, mul_lo};
    quot = div_lo;
    remv = div_hi;
`ifdef MULDIV_SIGNED_EN
    if (qneg_q)          prod = ~prod + 1'b1;
    if (qneg_q && !bz_q) quot = ~quot + 1'b1;
    if (rneg_q)          remv = ~remv + 1'b1;
`endif
    case (op_q)
      2'b00:   final_res = prod[WIDTH-1:0];
      2'b01:   final_res = prod[2*WIDTH-1:WIDTH];
      2'b10:   final_res = quot;
      default: final_res = remv;
    endcase
  end

  // Next-state and datapath update for the IDLE/RUN/FIN controller
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    opnd_d   = opnd_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    bz_d     = bz_q;
    result_d = result_q;
    dbz_d    = dbz_q;
`ifdef MULDIV_SIGNED_EN
    qneg_d   = qneg_q;
    rneg_d   = rneg_q;
`endif
    if (accept) begin
      state_d = S_RUN;
      cnt_d   = CW'(WIDTH);
      op_d    = op;
      opnd_d  = op[1] ? mag_b : mag_a;
      lo_d    = op[1] ? mag_a : mag_b;
      hi_d    = '0;
      bz_d    = (b == '0);
`ifdef MULDIV_SIGNED_EN
      qneg_d  = sa ^ sb;
      rneg_d  = sa;
`endif
    end else if (flush || state_q == S_FIN) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end else if (state_q == S_RUN) begin
      hi_d  = op_q[1] ? div_hi : mul_hi;
      lo_d  = op_q[1] ? div_lo : mul_lo;
      cnt_d = cnt_q - 1'b1;
      if (cnt_q == CW'(1)) begin
        state_d  = S_FIN;
        result_d = final_res;
        dbz_d    = op_q[1] & bz_q;
      end
    end
  end

  // State registers with synchronous active-high reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      opnd_q   <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      bz_q     <= 1'b0;
      result_q <= '0;
      dbz_q    <= 1'b0;
`ifdef MULDIV_SIGNED_EN
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      opnd_q   <= opnd_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      bz_q     <= bz_d;
      result_q <= result_d;
      dbz_q    <= dbz_d;
`ifdef MULDIV_SIGNED_EN
      qneg_q   <= qneg_d;
      rneg_q   <= rneg_d;
`endif
    end
  end

  assign busy        = (state_q == S_RUN);
  assign done        = (state_q == S_FIN);
  assign result      = result_q;
  assign div_by_zero = dbz_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_risc16_muldiv.sv
// Testbench for risc16_muldiv (WIDTH=16): directed vector table, hand-written
// flush/reset sequences, and random ops checked against an arithmetic model.
module tb_risc16_muldiv;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst, start, flush, sgn;
  logic [1:0]   op;
  logic [W-1:0] a, b;
  logic         busy, done, div_by_zero;
  logic [W-1:0] result;
  logic [1:0]   dbg_state;

  int checks = 0;
  int errors = 0;

  risc16_muldiv #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .flush(flush), .op(op), .sgn(sgn),
    .a(a), .b(b), .busy(busy), .done(done), .result(result),
    .div_by_zero(div_by_zero), .dbg_state(dbg_state)
  );

  // clock/reset block
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]   op;
    logic         sg;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] res;
    logic         dbz;
  } vec_t;

  vec_t vecs[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", name, got, exp);
    end
  endtask

  // Reference model from the arithmetic definition of each op
  function automatic void model(input logic [1:0] o, input logic s,
                                input logic [W-1:0] x, input logic [W-1:0] y,
                                output logic [W-1:0] r, output logic z);
    longint sx, sy, p, q;
    bit sg;
    sx = longint'(x);
    sy = longint'(y);
    sg = 1'b0;
`ifdef MULDIV_SIGNED_EN
    if (s) begin
      sg = 1'b1;
      sx = longint'($signed(x));
      sy = longint'($signed(y));
    end
`else
    if (s) sg = 1'b0;
`endif
    p = sx * sy;
    r = '0;
    case (o)
      2'b00: r = p[W-1:0];
      2'b01: r = p[2*W-1:W];
      2'b10: begin
        if (y == 0) r = '1;
        else if (sg && x == 16'h8000 && y == 16'hFFFF) r = 16'h8000;
        else begin q = sx / sy; r = q[W-1:0]; end
      end
      default: begin
        if (y == 0) r = x;
        else if (sg && x == 16'h8000 && y == 16'hFFFF) r = '0;
        else begin q = sx % sy; r = q[W-1:0]; end
      end
    endcase
    z = o[1] && (y == 0);
  endfunction

  // driver: issue one op and wait (bounded) for done
  task automatic run_op(input logic [1:0] o, input logic s,
                        input logic [W-1:0] x, input logic [W-1:0] y,
                        output logic [W-1:0] r, output logic z,
                        output int lat, output int busy_n);
    op = o; sgn = s; a = x; b = y; start = 1'b1;
    tick();
    start = 1'b0;
    lat = 1;
    busy_n = 0;
    while (!done && lat <= 40) begin
      if (busy) busy_n++;
      tick();
      lat++;
    end
    r = result;
    z = div_by_zero;
  endtask

  task automatic run_and_check(input string name, input logic [1:0] o, input logic s,
                               input logic [W-1:0] x, input logic [W-1:0] y,
                               input logic [W-1:0] er, input logic ez);
    logic [W-1:0] r;
    logic z;
    int lat, bn;
    run_op(o, s, x, y, r, z, lat, bn);
    check({name, " result"}, 32'(r), 32'(er));
    check({name, " dbz"}, 32'(z), 32'(ez));
    check({name, " latency"}, 32'(lat), 32'(W + 1));
    check({name, " busy cycles"}, 32'(bn), 32'(W));
    check({name, " busy at done"}, 32'(busy), 32'(0));
  endtask

  initial begin
    int done_seen;
    logic [W-1:0] er, xr, yr;
    logic ez;
    logic [1:0] ro;
    logic rs;

    rst = 1'b1; start = 1'b0; flush = 1'b0; sgn = 1'b0; op = '0; a = '0; b = '0;
    repeat (3) tick();
    check("reset busy", 32'(busy), 32'(0));
    check("reset done", 32'(done), 32'(0));
    check("reset result", 32'(result), 32'(0));
    check("reset dbz", 32'(div_by_zero), 32'(0));
    check("reset state", 32'(dbg_state), 32'(0));
    rst = 1'b0;
    tick();

    // directed vectors; consecutive entries issue back-to-back in the done cycle
    vecs.push_back('{2'b00, 1'b0, 16'h1234, 16'h0010, 16'h2340, 1'b0});
    vecs.push_back('{2'b01, 1'b0, 16'h1234, 16'h0010, 16'h0001, 1'b0});
    vecs.push_back('{2'b10, 1'b0, 16'd100,  16'd7,    16'h000E, 1'b0});
    vecs.push_back('{2'b11, 1'b0, 16'd100,  16'd7,    16'h0002, 1'b0});
    vecs.push_back('{2'b10, 1'b0, 16'h1234, 16'h0000, 16'hFFFF, 1'b1});
    vecs.push_back('{2'b11, 1'b0, 16'h1234, 16'h0000, 16'h1234, 1'b1});
    vecs.push_back('{2'b00, 1'b0, 16'hFFFF, 16'hFFFF, 16'h0001, 1'b0});
`ifdef MULDIV_SIGNED_EN
    vecs.push_back('{2'b10, 1'b1, 16'hFFF9, 16'h0002, 16'hFFFD, 1'b0});
    vecs.push_back('{2'b11, 1'b1, 16'hFFF9, 16'h0002, 16'hFFFF, 1'b0});
    vecs.push_back('{2'b10, 1'b1, 16'h8000, 16'hFFFF, 16'h8000, 1'b0});
    vecs.push_back('{2'b11, 1'b1, 16'h8000, 16'hFFFF, 16'h0000, 1'b0});
    vecs.push_back('{2'b00, 1'b1, 16'hFFFF, 16'hFFFF, 16'h0001, 1'b0});
    vecs.push_back('{2'b01, 1'b1, 16'hFFFF, 16'hFFFF, 16'h0000, 1'b0});
    vecs.push_back('{2'b10, 1'b1, 16'hFFF9, 16'h0000, 16'hFFFF, 1'b1});
    vecs.push_back('{2'b11, 1'b1, 16'hFFF9, 16'h0000, 16'hFFF9, 1'b1});
`else
    vecs.push_back('{2'b01, 1'b1, 16'hFFFF, 16'hFFFF, 16'hFFFE, 1'b0});
    vecs.push_back('{2'b10, 1'b1, 16'hFFF9, 16'h0002, 16'h7FFC, 1'b0});
`endif
    for (int i = 0; i < vecs.size(); i++)
      run_and_check($sformatf("vec%0d", i), vecs[i].op, vecs[i].sg, vecs[i].a,
                    vecs[i].b, vecs[i].res, vecs[i].dbz);
    tick();

    // start during busy must be ignored: original op completes on time
    op = 2'b00; sgn = 1'b0; a = 16'h1234; b = 16'h0010; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();
    op = 2'b10; a = 16'd9; b = 16'd3; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (W - 3) tick();
    check("ignored start done", 32'(done), 32'(1));
    check("ignored start result", 32'(result), 32'h2340);
    tick();

    // flush at busy cycle 5 with an ignored start before it
    run_and_check("pre-flush rem", 2'b11, 1'b0, 16'd100, 16'd7, 16'h0002, 1'b0);
    tick();
    op = 2'b00; a = 16'd3; b = 16'd5; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    op = 2'b10; a = 16'd9; b = 16'd0; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();
    check("busy before flush", 32'(busy), 32'(1));
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush busy", 32'(busy), 32'(0));
    check("flush done", 32'(done), 32'(0));
    done_seen = 0;
    for (int i = 0; i < 25; i++) begin
      if (done) done_seen++;
      tick();
    end
    check("flush no done", 32'(done_seen), 32'(0));
    check("flush result held", 32'(result), 32'h0002);
    check("flush dbz held", 32'(div_by_zero), 32'(0));

    // flush on the final RUN cycle still suppresses completion
    op = 2'b11; a = 16'h1234; b = 16'h0000; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (W - 1) tick();
    check("busy last run", 32'(busy), 32'(1));
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("late flush done", 32'(done), 32'(0));
    check("late flush busy", 32'(busy), 32'(0));
    check("late flush result", 32'(result), 32'h0002);
    check("late flush dbz", 32'(div_by_zero), 32'(0));

    // reset at busy cycle 8 of a divide-by-zero op
    run_and_check("pre-reset div0", 2'b10, 1'b0, 16'h0055, 16'h0000, 16'hFFFF, 1'b1);
    op = 2'b01; a = 16'hFFFF; b = 16'hFFFF; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (7) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midop reset busy", 32'(busy), 32'(0));
    check("midop reset done", 32'(done), 32'(0));
    check("midop reset result", 32'(result), 32'(0));
    check("midop reset dbz", 32'(div_by_zero), 32'(0));
    check("midop reset state", 32'(dbg_state), 32'(0));
    done_seen = 0;
    for (int i = 0; i < 25; i++) begin
      if (done) done_seen++;
      tick();
    end
    check("post reset no done", 32'(done_seen), 32'(0));

    // random ops against the reference model, mixed gaps and back-to-back
    for (int i = 0; i < 150; i++) begin
      ro = 2'($urandom_range(0, 3));
      rs = 1'($urandom_range(0, 1));
      xr = 16'($urandom);
      yr = 16'($urandom);
      case ($urandom_range(0, 7))
        0: yr = '0;
        1: begin xr = 16'h8000; yr = 16'hFFFF; end
        2: yr = 16'($urandom_range(1, 15));
        default: ;
      endcase
      model(ro, rs, xr, yr, er, ez);
      run_and_check($sformatf("rand%0d op%0d s%0d %h %h", i, ro, rs, xr, yr),
                    ro, rs, xr, yr, er, ez);
      repeat ($urandom_range(0, 2)) tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
